// File: rtl/beat_timing_gen_pkg.sv
// beat_timing_gen_pkg: beat encodings, run state and defaults shared with the hardwired controller.
package beat_timing_gen_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [2:0] W1_OH = 3'b001;
    localparam logic [2:0] W2_OH = 3'b010;
    localparam logic [2:0] W3_OH = 3'b100;

    typedef enum logic {HALT, ACTIVE} state_t;

    function automatic logic [2:0] beat_oh(input int b);
        return b == 2 ? W2_OH : b == 3 ? W3_OH : W1_OH;
    endfunction

endpackage

// File: rtl/beat_timing_gen_if.sv
// beat_timing_gen_if: controller/panel requests in, one-hot beats and performance counters out.
interface beat_timing_gen_if
    import beat_timing_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             QD;
    logic             STEP;
    logic             SHORT;
    logic             LONG;
    logic             STOP;
    logic [2:0]       W;
    logic             RUN;
    logic             INSTR_END;
    logic [CNT_W-1:0] BEAT_CNT;
    logic [CNT_W-1:0] INSTR_CNT;

    modport master (
        output QD, STEP, SHORT, LONG, STOP,
        input  W, RUN, INSTR_END, BEAT_CNT, INSTR_CNT
    );

    modport slave (
        input  QD, STEP, SHORT, LONG, STOP,
        output W, RUN, INSTR_END, BEAT_CNT, INSTR_CNT
    );
endinterface

// File: rtl/beat_timing_gen_qd_edge_detect.sv
// beat_timing_gen_qd_edge_detect: start-button rising-edge pulse; resets to 1 so a held button never fires.
module beat_timing_gen_qd_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic q;

    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b1;
        else     q <= d;

    assign rise = d & ~q;
endmodule

// File: rtl/beat_timing_gen.sv
// beat_timing_gen: W1..W3 beat sequencer with run/halt control, single-step and beat/instruction counters.
module beat_timing_gen
    import beat_timing_gen_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int START_BEAT = 1
) (
    input logic              T3,
    input logic              CLR,
    beat_timing_gen_if.slave bus
);
    localparam logic [2:0] START_OH = beat_oh(START_BEAT);

    state_t           state, state_n;
    logic [2:0]       beat, beat_n;
    logic             active, qd_rise, closes;
    logic [CNT_W-1:0] beat_cnt, instr_cnt;

    beat_timing_gen_qd_edge_detect u_qd_edge (
        .clk  (T3),
        .rst  (CLR),
        .d    (bus.QD),
        .rise (qd_rise)
    );

    assign active = state == ACTIVE;

    // SHORT only matters in W1 and LONG only in W2; W3 always closes.
    always_comb begin
        beat_n = W1_OH;
        closes = 1'b1;
        if (beat == W1_OH) begin
            beat_n = bus.SHORT ? W1_OH : W2_OH;
            closes = bus.SHORT;
        end else if (beat == W2_OH) begin
            beat_n = bus.LONG ? W3_OH : W1_OH;
            closes = !bus.LONG;
        end
    end

    always_comb begin
        state_n = state;
        if (active) state_n = (bus.STOP || (bus.STEP && closes)) ? HALT : ACTIVE;
        else        state_n = qd_rise ? ACTIVE : HALT;
    end

    // The beat register keeps advancing on the halting cycle so resume picks up the right beat.
    always_ff @(posedge T3 or posedge CLR)
        if (CLR) begin
            state     <= HALT;
            beat      <= START_OH;
            beat_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            state     <= state_n;
            beat      <= active ? beat_n : beat;
            beat_cnt  <= active ? beat_cnt + CNT_W'(1) : beat_cnt;
            instr_cnt <= (active && closes) ? instr_cnt + CNT_W'(1) : instr_cnt;
        end

    assign bus.W         = active ? beat : 3'b000;
    assign bus.RUN       = active;
    assign bus.INSTR_END = active && closes;
    assign bus.BEAT_CNT  = beat_cnt;
    assign bus.INSTR_CNT = instr_cnt;
endmodule

// File: tb/tb_beat_timing_gen.sv
// tb_beat_timing_gen: directed and random steps against a beat-level reference model, 16-bit and 4-bit counters.
module tb_beat_timing_gen;
    logic T3 = 1'b0;
    logic CLR = 1'b1;
    int checks = 0;
    int errors = 0;

    bit m_run;
    bit m_qdp;
    int m_beat;
    int m_bc;
    int m_ic;

    beat_timing_gen_if #(.CNT_W(16)) b16 ();
    beat_timing_gen_if #(.CNT_W(4))  b4 ();

    assign b4.QD    = b16.QD;
    assign b4.STEP  = b16.STEP;
    assign b4.SHORT = b16.SHORT;
    assign b4.LONG  = b16.LONG;
    assign b4.STOP  = b16.STOP;

    beat_timing_gen #(.CNT_W(16), .START_BEAT(1)) dut16 (.T3(T3), .CLR(CLR), .bus(b16.slave));
    beat_timing_gen #(.CNT_W(4),  .START_BEAT(1)) dut4  (.T3(T3), .CLR(CLR), .bus(b4.slave));

    always #5 T3 = ~T3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_qdp  = 1;
        m_beat = 1;
        m_bc   = 0;
        m_ic   = 0;
    endtask

    // One clock: drive inputs, compare against the model, advance the model, move to the next falling edge.
    task automatic step(input bit qd, input bit st, input bit sh, input bit lg, input bit sp);
        int  nb;
        bit  ends;
        logic [2:0] exp_w;
        b16.QD    = qd;
        b16.STEP  = st;
        b16.SHORT = sh;
        b16.LONG  = lg;
        b16.STOP  = sp;
        if (m_beat == 1) begin
            ends = sh;
            nb   = sh ? 1 : 2;
        end else if (m_beat == 2) begin
            ends = !lg;
            nb   = lg ? 3 : 1;
        end else begin
            ends = 1;
            nb   = 1;
        end
        exp_w = m_run ? 3'(1 << (m_beat - 1)) : 3'd0;
        #1;
        chk("W", b16.W, exp_w);
        chk("W_4", b4.W, exp_w);
        chk("RUN", b16.RUN, m_run);
        chk("INSTR_END", b16.INSTR_END, m_run && ends);
        chk("BEAT_CNT", b16.BEAT_CNT, m_bc % 65536);
        chk("INSTR_CNT", b16.INSTR_CNT, m_ic % 65536);
        chk("BEAT_CNT_4", b4.BEAT_CNT, m_bc % 16);
        chk("INSTR_CNT_4", b4.INSTR_CNT, m_ic % 16);
        if (m_run) begin
            m_bc++;
            if (ends) m_ic++;
            m_beat = nb;
            if (sp || (st && ends)) m_run = 0;
        end else if (qd && !m_qdp) begin
            m_run = 1;
        end
        m_qdp = qd;
        @(negedge T3);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_W"}, b16.W, 0);
        chk({tag, "_RUN"}, b16.RUN, 0);
        chk({tag, "_IEND"}, b16.INSTR_END, 0);
        chk({tag, "_BCNT"}, b16.BEAT_CNT, 0);
        chk({tag, "_ICNT"}, b16.INSTR_CNT, 0);
        chk({tag, "_BCNT_4"}, b4.BEAT_CNT, 0);
    endtask

    // Reset lands mid-cycle, away from any clock edge, to prove it acts asynchronously.
    task automatic reset_mid();
        #2 CLR = 1'b1;
        #1 check_cleared("async_clr");
        model_reset();
        @(negedge T3);
        CLR = 1'b0;
    endtask

    initial begin
        b16.QD = 0; b16.STEP = 0; b16.SHORT = 0; b16.LONG = 0; b16.STOP = 0;
        model_reset();
        @(negedge T3);
        check_cleared("reset");
        CLR = 1'b0;

        // Plain two-beat instructions
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("start_W1", b16.W, 3'b001);
        repeat (6) step(0, 0, 0, 0, 0);
        chk("bc_after6", b16.BEAT_CNT, 6);
        chk("ic_after6", b16.INSTR_CNT, 3);

        // Alternate one-beat (SHORT) and three-beat (LONG) instructions
        repeat (3) begin
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 0);
        end
        chk("ic_short_long", b16.INSTR_CNT, 9);

        // STOP together with LONG in W2 resumes at W3
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("stop_W", b16.W, 3'b000);
        chk("stop_RUN", b16.RUN, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("resume_W3", b16.W, 3'b100);
        step(0, 0, 0, 0, 0);
        chk("resume_W1", b16.W, 3'b001);

        // Single-step: one 2-beat instruction per QD edge, held QD does not re-trigger
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("step_halt", b16.RUN, 0);
        repeat (6) step(1, 1, 0, 0, 0);
        chk("step_held", b16.RUN, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        chk("step_again", b16.RUN, 0);

        // Long run to wrap the 4-bit counters
        step(1, 0, 0, 0, 0);
        repeat (40) step(0, 0, 0, 0, 0);

        // Reach W3, then reset with QD held high across release
        for (int i = 0; i < 4 && !(m_run && m_beat == 3); i++) step(0, 0, 0, 1, 0);
        chk("at_W3", b16.W, 3'b100);
        b16.QD = 1;
        reset_mid();
        repeat (3) step(1, 0, 0, 0, 0);
        chk("held_qd_halt", b16.RUN, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("restart_W1", b16.W, 3'b001);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) reset_mid();
            step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
